fdc_head_ctrl: RTL and testbench
================================

Name: fdc_head_ctrl

Overview:
- Controller-side initiator for the emulated floppy drive.
- Accepts seek or read-sector commands and drives select, motor and step lines toward the drive.
- Uses the drive's track, sector, header/data and index feedback to position the head and locate the target sector.
- During a read, emits one strobe per data byte passing the head; the FDC core uses these to move data to/from the image buffer.

Parameters:
- STEP_PULSE_CLKS, 16, width of each step pulse in clk cycles.
- STEP_GUARD_CLKS, 8, clk cycles after a step falls before `ready` is sampled.
- SEARCH_REVS, 5, index pulses allowed while searching for a sector header before record-not-found.
- MOTOR_OFF_REVS, 10, idle index pulses before motor drop (optional feature only).
- MAX_TRACK, 84, highest legal track.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted when valid&&ready
- cmd_read  in  1  0=seek only, 1=seek+read sector
- cmd_track  in  7  target track
- cmd_sector  in  5  target sector number
- select  out  1  drive select
- motor_on  out  1  motor request
- step_in  out  1  step toward track 0 (drive decrements)
- step_out  out  1  step away from track 0 (drive increments)
- track  in  7  drive current track
- sector  in  5  sector under head
- sector_hdr  in  1  header under head
- sector_data  in  1  data field under head
- dclk_en  in  1  byte clock enable from drive
- ready  in  1  drive at speed, head settled
- index  in  1  index signal
- byte_en  out  1  one-cycle strobe per data byte of target sector
- byte_idx  out  11  index of current byte, 0-based
- done  out  1  one-cycle completion pulse
- err  out  2  valid with done: 0 ok, 1 bad track, 2 record not found

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: all outputs 0 except cmd_ready=1; state IDLE.
- `index` edge detection: one-cycle registered delay; a count is a 0->1 transition.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: latch track, sector and op; cmd_ready=0 next cycle.
  - If cmd_track>MAX_TRACK: go to FINISH with err=1 and no step.
  - Otherwise set select=1, motor_on=1 and go to SPINUP.
- SPINUP: wait for ready=1 (no timeout), then go to COMPARE.
- COMPARE
  - track==target: go to SEARCH if read, else FINISH with err=0.
  - track<target: assert step_out; track>target: assert step_in. Go to STEP.
- STEP: hold the step line for STEP_PULSE_CLKS cycles, deassert, go to SETTLE.
- SETTLE: count STEP_GUARD_CLKS, then wait for ready=1, then go to COMPARE.
  - Result: exactly |target-start| pulses, never both lines high at once.
- SEARCH
  - Clear the revolution counter on entry; increment on each index rising edge.
  - On sector_hdr rising edge with sector==target: go to WAITDATA.
  - When the counter reaches SEARCH_REVS: go to FINISH with err=2.
- WAITDATA: on sector_data=1, set byte_idx=0 and go to DATA.
- DATA
  - Each dclk_en while sector_data=1: byte_en=1 the same cycle, byte_idx increments after.
  - Width rule: byte_idx wraps at 2047, which is unreachable with legal sector_len.
  - sector_data falling edge: go to FINISH with err=0.
- FINISH: done=1 for one cycle, err held until the next command accept; then IDLE.
- Select and motor persist after FINISH.
- cmd_valid while busy is ignored, not queued.
- reset_n low mid-operation: step lines and byte_en drop immediately (async); no done is issued.

Optional Feature:
- Macro: FDC_HEAD_CTRL_MOTOR_AUTO_OFF_EN.
- Defined: in IDLE, count index rising edges. At MOTOR_OFF_REVS, clear motor_on and select. Any accepted command clears the count.
- Undefined: motor_on and select stay high from the first command until reset.

Test Plan:
- Seek: drive at track 0, cmd_read=0, cmd_track=3 -> exactly 3 step_out pulses of 16 clk, 0 step_in, done=1, err=0, track=3.
- Seek back: from track 3, cmd_track=1 -> 2 step_in pulses, done, err=0.
- Read: spt=5, base=1, sector_len=256, cmd_sector=2 -> 256 byte_en strobes, byte_idx 0..255, done after sector 2 data ends, err=0.
- Not found: cmd_sector=9 with spt=5 -> no byte_en; done with err=2 on the 5th index rising edge after entering SEARCH.
- Bad track: cmd_track=90 -> done within 2 cycles, err=1, no step pulses, motor_on stays 0.
- Reset mid-STEP: assert reset_n=0 during a step_out pulse -> step_out=0 asynchronously, cmd_ready=1 after release, no done.

Source files
------------

// File: rtl/fdc_head_ctrl.sv
// Floppy head controller: seeks the drive to a target track and, for reads, locates a sector and strobes its data bytes.
// Optional motor/select auto-off after idle revolutions is enabled by defining FDC_HEAD_CTRL_MOTOR_AUTO_OFF_EN.
module fdc_head_ctrl #(
  parameter int STEP_PULSE_CLKS = 16,
  parameter int STEP_GUARD_CLKS = 8,
  parameter int SEARCH_REVS     = 5,
  parameter int MOTOR_OFF_REVS  = 10,
  parameter int MAX_TRACK       = 84
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [6:0]  cmd_track,
  input  logic [4:0]  cmd_sector,
  output logic        select,
  output logic        motor_on,
  output logic        step_in,
  output logic        step_out,
  input  logic [6:0]  track,
  input  logic [4:0]  sector,
  input  logic        sector_hdr,
  input  logic        sector_data,
  input  logic        dclk_en,
  input  logic        ready,
  input  logic        index,
  output logic        byte_en,
  output logic [10:0] byte_idx,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SPINUP   = 4'd1;
  localparam logic [3:0] S_COMPARE  = 4'd2;
  localparam logic [3:0] S_STEP     = 4'd3;
  localparam logic [3:0] S_SETTLE   = 4'd4;
  localparam logic [3:0] S_SEARCH   = 4'd5;
  localparam logic [3:0] S_WAITDATA = 4'd6;
  localparam logic [3:0] S_DATA     = 4'd7;
  localparam logic [3:0] S_FINISH   = 4'd8;

  // Revolution counters share one width, sized for the larger of the two limits.
  localparam int REV_MAX = (SEARCH_REVS > MOTOR_OFF_REVS) ? SEARCH_REVS : MOTOR_OFF_REVS;
  localparam int REV_W   = $clog2(REV_MAX + 1);

  localparam logic [15:0]      PULSE_LAST = 16'(STEP_PULSE_CLKS - 1);
  localparam logic [15:0]      GUARD_L    = 16'(STEP_GUARD_CLKS);
  localparam logic [REV_W-1:0] REVS_LAST  = REV_W'(SEARCH_REVS - 1);
  localparam logic [6:0]       MAX_TRK_L  = 7'(MAX_TRACK);

  logic [3:0]       r_state;
  logic [3:0]       w_nextState;
  logic [6:0]       r_tgtTrack;
  logic [4:0]       r_tgtSector;
  logic             r_read;
  logic             r_select;
  logic             r_motor;
  logic             r_stepIn;
  logic             r_stepOut;
  logic [15:0]      r_cnt;
  logic [REV_W-1:0] r_revCnt;
  logic [10:0]      r_byteIdx;
  logic [1:0]       r_err;
  logic             r_indexD;
  logic             r_hdrD;
  logic             r_dataD;

  logic w_accept;
  logic w_badTrack;
  logic w_onTrack;
  logic w_pulseEnd;
  logic w_guardDone;
  logic w_indexRise;
  logic w_hdrMatch;
  logic w_revTimeout;
  logic w_dataFall;
  logic w_byteStrobe;

  assign w_accept     = (r_state == S_IDLE) && cmd_valid;
  assign w_badTrack   = cmd_track > MAX_TRK_L;
  assign w_onTrack    = track == r_tgtTrack;
  assign w_pulseEnd   = (r_state == S_STEP) && (r_cnt == PULSE_LAST);
  assign w_guardDone  = r_cnt >= GUARD_L;
  assign w_indexRise  = index && !r_indexD;
  assign w_hdrMatch   = sector_hdr && !r_hdrD && (sector == r_tgtSector);
  assign w_revTimeout = w_indexRise && (r_revCnt == REVS_LAST);
  assign w_dataFall   = r_dataD && !sector_data;
  assign w_byteStrobe = (r_state == S_DATA) && dclk_en && sector_data;

  assign cmd_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_FINISH);
  assign byte_en   = w_byteStrobe;
  assign byte_idx  = r_byteIdx;
  assign err       = r_err;
  assign select    = r_select;
  assign motor_on  = r_motor;
  assign step_in   = r_stepIn;
  assign step_out  = r_stepOut;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid) w_nextState = w_badTrack ? S_FINISH : S_SPINUP;
      S_SPINUP:   if (ready) w_nextState = S_COMPARE;
      S_COMPARE: begin
        if (!w_onTrack)  w_nextState = S_STEP;
        else if (r_read) w_nextState = S_SEARCH;
        else             w_nextState = S_FINISH;
      end
      S_STEP:     if (w_pulseEnd) w_nextState = S_SETTLE;
      S_SETTLE:   if (w_guardDone && ready) w_nextState = S_COMPARE;
      S_SEARCH: begin
        if (w_hdrMatch)        w_nextState = S_WAITDATA;
        else if (w_revTimeout) w_nextState = S_FINISH;
      end
      S_WAITDATA: if (sector_data) w_nextState = S_DATA;
      S_DATA:     if (w_dataFall) w_nextState = S_FINISH;
      S_FINISH:   w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_indexD <= 1'b0;
      r_hdrD   <= 1'b0;
      r_dataD  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_indexD <= index;
      r_hdrD   <= sector_hdr;
      r_dataD  <= sector_data;
    end
  end

  // err stays visible after done until the next command is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tgtTrack  <= 7'd0;
      r_tgtSector <= 5'd0;
      r_read      <= 1'b0;
      r_err       <= 2'd0;
    end else if (w_accept) begin
      r_tgtTrack  <= cmd_track;
      r_tgtSector <= cmd_sector;
      r_read      <= cmd_read;
      r_err       <= w_badTrack ? 2'd1 : 2'd0;
    end else if ((r_state == S_SEARCH) && !w_hdrMatch && w_revTimeout) begin
      r_err <= 2'd2;
    end
  end

`ifdef FDC_HEAD_CTRL_MOTOR_AUTO_OFF_EN
  localparam logic [REV_W-1:0] MOTOR_LAST = REV_W'(MOTOR_OFF_REVS - 1);
  logic [REV_W-1:0] r_idleRevs;

  // Idle revolutions are counted only while the motor spins; a legal command restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_select   <= 1'b0;
      r_motor    <= 1'b0;
      r_idleRevs <= '0;
    end else if (w_accept) begin
      r_idleRevs <= '0;
      if (!w_badTrack) begin
        r_select <= 1'b1;
        r_motor  <= 1'b1;
      end
    end else if ((r_state == S_IDLE) && w_indexRise && r_motor) begin
      if (r_idleRevs == MOTOR_LAST) begin
        r_select   <= 1'b0;
        r_motor    <= 1'b0;
        r_idleRevs <= '0;
      end else begin
        r_idleRevs <= r_idleRevs + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_select <= 1'b0;
      r_motor  <= 1'b0;
    end else if (w_accept && !w_badTrack) begin
      r_select <= 1'b1;
      r_motor  <= 1'b1;
    end
  end
`endif

  // One timer serves both the step pulse width and the post-step guard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_COMPARE) || w_pulseEnd) begin
      r_cnt <= 16'd0;
    end else if (r_state == S_STEP) begin
      r_cnt <= r_cnt + 16'd1;
    end else if ((r_state == S_SETTLE) && !w_guardDone) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stepOut <= 1'b0;
      r_stepIn  <= 1'b0;
    end else if ((r_state == S_COMPARE) && !w_onTrack) begin
      r_stepOut <= track < r_tgtTrack;
      r_stepIn  <= track > r_tgtTrack;
    end else if (w_pulseEnd) begin
      r_stepOut <= 1'b0;
      r_stepIn  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_revCnt <= '0;
    end else if (r_state == S_COMPARE) begin
      r_revCnt <= '0;
    end else if ((r_state == S_SEARCH) && w_indexRise) begin
      r_revCnt <= r_revCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byteIdx <= 11'd0;
    end else if ((r_state == S_WAITDATA) && sector_data) begin
      r_byteIdx <= 11'd0;
    end else if (w_byteStrobe) begin
      r_byteIdx <= r_byteIdx + 11'd1;
    end
  end

endmodule

// File: tb/tb_fdc_head_ctrl.sv
// Bench for fdc_head_ctrl: a behavioural drive model feeds the controller, a scoreboard predicts each
// command's outcome from track arithmetic and the sector layout, and a monitor checks every done and byte strobe.
module tb_fdc_head_ctrl;

   localparam int SPT    = 5;
   localparam int BASE   = 1;
   localparam int MAXTRK = 84;
   localparam int PULSE  = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_read;
   logic [6:0]  cmd_track;
   logic [4:0]  cmd_sector;
   logic        select;
   logic        motor_on;
   logic        step_in;
   logic        step_out;
   logic [6:0]  track;
   logic [4:0]  sector;
   logic        sector_hdr;
   logic        sector_data;
   logic        dclk_en;
   logic        ready;
   logic        index;
   logic        byte_en;
   logic [10:0] byte_idx;
   logic        done;
   logic [1:0]  err;

   typedef struct {
      int err;
      int nOut;
      int nIn;
      int nBytes;
      int trk;
      int motor;
   } exp_t;

   exp_t sbQ[$];
   int   byteQ[$];
   int   cmpCount = 0;
   int   failCount = 0;
   int   drvTrack = 0;
   int   sectorLen = 256;
   int   motorModel = 0;
   int   obsOut, obsIn, obsBytes, cyc, wOut, wIn;
   logic prevOut, prevIn;

   fdc_head_ctrl dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_read(cmd_read), .cmd_track(cmd_track), .cmd_sector(cmd_sector),
      .select(select), .motor_on(motor_on), .step_in(step_in), .step_out(step_out),
      .track(track), .sector(sector), .sector_hdr(sector_hdr), .sector_data(sector_data),
      .dclk_en(dclk_en), .ready(ready), .index(index), .byte_en(byte_en),
      .byte_idx(byte_idx), .done(done), .err(err)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Records one comparison and reports it when the values disagree.
   task automatic checkVal(input string name, input int act, input int exp);
      cmpCount++;
      if (act != exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Drive-side inputs change one time unit after the rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive mechanics: the head moves one track per step pulse, and ready needs spin-up and head settling.
   initial begin
      int   motorAge;
      int   settle;
      logic lastOut;
      logic lastIn;
      motorAge = 0;
      settle = 0;
      lastOut = 1'b0;
      lastIn = 1'b0;
      track = 7'd0;
      ready = 1'b0;
      forever begin
         tick(1);
         if (step_out && !lastOut && drvTrack < 127) drvTrack++;
         if (step_in && !lastIn && drvTrack > 0) drvTrack--;
         if ((lastOut && !step_out) || (lastIn && !step_in)) settle = 6;
         else if (settle > 0) settle--;
         lastOut = step_out;
         lastIn = step_in;
         if (!motor_on) motorAge = 0;
         else if (motorAge < 30) motorAge++;
         track = 7'(drvTrack);
         ready = (motorAge >= 20) && !step_out && !step_in && (settle == 0);
      end
   end

   // Disk rotation: index mark, then SPT sectors each with a header and a data field of sectorLen bytes.
   initial begin
      index = 1'b0;
      sector = 5'd0;
      sector_hdr = 1'b0;
      sector_data = 1'b0;
      dclk_en = 1'b0;
      forever begin
         index = 1'b1;
         tick(4);
         index = 1'b0;
         tick(4);
         for (int s = 0; s < SPT; s++) begin
            sector = 5'(BASE + s);
            sector_hdr = 1'b1;
            tick(3);
            sector_hdr = 1'b0;
            tick(4);
            sector_data = 1'b1;
            tick(1);
            for (int b = 0; b < sectorLen; b++) begin
               dclk_en = 1'b1;
               tick(1);
               dclk_en = 1'b0;
               tick(1);
            end
            sector_data = 1'b0;
            tick(4);
         end
      end
   end

   // Compares a completed command against its predicted outcome.
   task automatic checkOutput(input exp_t e);
      checkVal("err", int'(err), e.err);
      checkVal("step_out pulses", obsOut, e.nOut);
      checkVal("step_in pulses", obsIn, e.nIn);
      checkVal("byte strobes", obsBytes, e.nBytes);
      checkVal("drive track", drvTrack, e.trk);
      checkVal("motor_on", int'(motor_on), e.motor);
      checkVal("select", int'(select), e.motor);
      checkVal("bytes left over", byteQ.size(), 0);
      if (e.err == 1) checkVal("bad-track done within 2 cycles", int'(cyc <= 2), 1);
   endtask

   // Monitor: watches the DUT on falling edges, decoupled from stimulus.
   initial begin
      prevOut = 1'b0;
      prevIn = 1'b0;
      wOut = 0;
      wIn = 0;
      obsOut = 0;
      obsIn = 0;
      obsBytes = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prevOut = 1'b0;
            prevIn = 1'b0;
            wOut = 0;
            wIn = 0;
            obsOut = 0;
            obsIn = 0;
            obsBytes = 0;
            cyc = 0;
            continue;
         end
         if (cmd_valid && cmd_ready) begin
            obsOut = 0;
            obsIn = 0;
            obsBytes = 0;
            cyc = 0;
         end else begin
            cyc++;
         end
         if (step_out || step_in) checkVal("step lines exclusive", int'(step_out && step_in), 0);
         if (step_out) begin
            if (!prevOut) obsOut++;
            wOut++;
         end else if (prevOut) begin
            checkVal("step_out width", wOut, PULSE);
            wOut = 0;
         end
         if (step_in) begin
            if (!prevIn) obsIn++;
            wIn++;
         end else if (prevIn) begin
            checkVal("step_in width", wIn, PULSE);
            wIn = 0;
         end
         prevOut = step_out;
         prevIn = step_in;
         if (byte_en) begin
            obsBytes++;
            checkVal("byte_en expected", int'(byteQ.size() > 0), 1);
            if (byteQ.size() > 0) checkVal("byte_idx", int'(byte_idx), byteQ.pop_front());
         end
         if (done) begin
            checkVal("done expected", int'(sbQ.size() > 0), 1);
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
         end
      end
   end

   // Presents one command for a single cycle while the controller is idle.
   task automatic driveCmd(input int rd, input int trk, input int sec);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_read = rd[0];
      cmd_track = 7'(trk);
      cmd_sector = 5'(sec);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Predicts the command outcome from the drive position and sector layout, then issues it.
   task automatic applyStimulus(input int rd, input int trk, input int sec);
      exp_t e;
      int   waitC;
      waitC = 0;
      @(negedge clk);
      while (!cmd_ready && waitC < 200) begin
         @(negedge clk);
         waitC++;
      end
      checkVal("cmd_ready before issue", int'(cmd_ready), 1);
      if (!cmd_ready) return;
      if (trk > MAXTRK) begin
         e = '{1, 0, 0, 0, drvTrack, motorModel};
      end else begin
         motorModel = 1;
         e.nOut = (trk > drvTrack) ? trk - drvTrack : 0;
         e.nIn = (drvTrack > trk) ? drvTrack - trk : 0;
         e.trk = trk;
         e.motor = 1;
         e.err = 0;
         e.nBytes = 0;
         if (rd != 0) begin
            if (sec >= BASE && sec < BASE + SPT) begin
               e.nBytes = sectorLen;
               for (int b = 0; b < sectorLen; b++) byteQ.push_back(b);
            end else begin
               e.err = 2;
            end
         end
      end
      sbQ.push_back(e);
      driveCmd(rd, trk, sec);
   endtask

   // Waits, with a cycle budget, until every predicted result has been consumed.
   task automatic waitIdle();
      for (int i = 0; i < 40000 && sbQ.size() > 0; i++) @(negedge clk);
      checkVal("results outstanding after wait", sbQ.size(), 0);
      sbQ.delete();
      byteQ.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (150000) @(posedge clk);
      $display("[TB] FAIL watchdog: simulation exceeded 150000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      reset_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_read = 1'b0;
      cmd_track = 7'd0;
      cmd_sector = 5'd0;
      repeat (5) @(negedge clk);
      checkVal("reset cmd_ready", int'(cmd_ready), 1);
      checkVal("reset select", int'(select), 0);
      checkVal("reset motor_on", int'(motor_on), 0);
      checkVal("reset step_out", int'(step_out), 0);
      checkVal("reset step_in", int'(step_in), 0);
      checkVal("reset done", int'(done), 0);
      checkVal("reset err", int'(err), 0);
      checkVal("reset byte_en", int'(byte_en), 0);
      checkVal("reset byte_idx", int'(byte_idx), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      applyStimulus(0, 90, 0);
      waitIdle();
      applyStimulus(0, 3, 0);
      waitIdle();
      applyStimulus(0, 1, 0);
      waitIdle();
      applyStimulus(1, 1, 2);
      waitIdle();
      applyStimulus(1, 1, 9);
      waitIdle();

      sectorLen = 64;
      for (int n = 0; n < 6; n++) begin
         t = ($urandom_range(0, 9) == 0) ? 85 + $urandom_range(0, 7) : $urandom_range(0, 40);
         applyStimulus($urandom_range(0, 1), t, $urandom_range(0, 6));
         waitIdle();
      end

      // Reset in the middle of a step pulse: lines drop at once and no completion follows.
      @(negedge clk);
      checkVal("cmd_ready before reset test", int'(cmd_ready), 1);
      driveCmd(0, drvTrack + 3, 0);
      for (int i = 0; i < 2000 && !step_out; i++) @(negedge clk);
      checkVal("step_out seen before reset", int'(step_out), 1);
      repeat (4) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkVal("async step_out drop", int'(step_out), 0);
      checkVal("async step_in drop", int'(step_in), 0);
      checkVal("async byte_en drop", int'(byte_en), 0);
      checkVal("cmd_ready in reset", int'(cmd_ready), 1);
      motorModel = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      checkVal("cmd_ready after reset", int'(cmd_ready), 1);
      checkVal("motor_on after reset", int'(motor_on), 0);
      checkVal("done after reset", int'(done), 0);

      applyStimulus(0, 2, 0);
      waitIdle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
